// File: rtl/dram_cmd_arbiter.sv
// dram_cmd_arbiter: shares the DRAM controller command/write-data port
// between NUM_REQ requesters using round-robin arbitration, gates commands
// by per-bank permission, and returns read data to the issuing requester
// through an in-order tag FIFO.
// Optional macro DRAM_ARB_ROW_HIT_EN adds row-hit preference with a
// limit of three consecutive grants that bypass round-robin order.
module dram_cmd_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int CMD_W     = 34,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 16,
  parameter int TAG_AW    = 4
) (
  input  logic                      clk,
  input  logic                      power_on_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*CMD_W-1:0]  req_cmd,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [CMD_W-1:0]          command,
  output logic                      valid,
  output logic [DATA_W-1:0]         write_data,
  input  logic [7:0]                ba_cmd_pm,
  input  logic [DATA_W-1:0]         read_data,
  input  logic                      read_data_valid,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [TAG_AW:0]           rd_outstanding,
  output logic                      err_unexp_rd
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  // Per-requester views of the packed command and data buses
  logic [CMD_W-1:0]  cmd_a   [NUM_REQ];
  logic [DATA_W-1:0] wdata_a [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign cmd_a[k]   = req_cmd[k*CMD_W +: CMD_W];
    assign wdata_a[k] = req_wdata[k*DATA_W +: DATA_W];
  end

  // Registered state
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  tag_mem_q [TAG_DEPTH];
  logic [IDX_W-1:0]  tag_mem_d [TAG_DEPTH];
  logic [TAG_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [TAG_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAG_AW:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              err_q, err_d;

  logic               tag_full;
  logic [NUM_REQ-1:0] elig;
  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;
  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [CMD_W-1:0]   gnt_cmd;
  logic               gnt_rd;
  logic               push;
  logic               pop;

  // Returns {found, index} of the first set mask bit at or after start, wrapping
  function automatic logic [IDX_W:0] pick_first(input logic [NUM_REQ-1:0] mask,
                                                 input logic [IDX_W-1:0]   start);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] ci;
    int               c;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = int'(start) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      ci = c[IDX_W-1:0];
      if (!found && mask[ci]) begin
        found = 1'b1;
        idx   = ci;
      end
    end
    return {found, idx};
  endfunction

  assign tag_full = (cnt_q == (TAG_AW+1)'(TAG_DEPTH));

  // Eligibility: pending, bank permitted, and reads held off while the tag FIFO is full
  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      elig[k] = req_valid[k] && ba_cmd_pm[cmd_a[k][2:0]] && !(cmd_a[k][31] && tag_full);
    end
  end

  // Plain round-robin choice among eligible requesters
  always_comb begin
    {rr_found, rr_idx} = pick_first(elig, rr_ptr_q);
  end

`ifdef DRAM_ARB_ROW_HIT_EN
  logic [12:0]        row_tbl_q [8];
  logic [12:0]        row_tbl_d [8];
  logic [7:0]         row_vld_q, row_vld_d;
  logic [1:0]         hit_cnt_q, hit_cnt_d;
  logic [NUM_REQ-1:0] hit_mask;
  logic               hit_found;
  logic [IDX_W-1:0]   hit_idx;

  // Eligible requesters whose row matches the last row issued to their bank
  always_comb begin
    hit_mask = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      hit_mask[k] = elig[k] && row_vld_q[cmd_a[k][2:0]] &&
                    (row_tbl_q[cmd_a[k][2:0]] == cmd_a[k][29:17]);
    end
    {hit_found, hit_idx} = pick_first(hit_mask, rr_ptr_q);
  end

  // Prefer row hits over RR order, but force a pure RR grant after three bypasses
  always_comb begin
    gnt_found = rr_found;
    gnt_idx   = rr_idx;
    hit_cnt_d = hit_cnt_q;
    if (rr_found) begin
      if (hit_cnt_q == 2'd3) begin
        hit_cnt_d = 2'd0;
      end else if (hit_found && (hit_idx != rr_idx)) begin
        gnt_idx   = hit_idx;
        hit_cnt_d = hit_cnt_q + 2'd1;
      end else begin
        hit_cnt_d = 2'd0;
      end
    end
  end

  // Remember the row of every issued command per bank
  always_comb begin
    row_tbl_d = row_tbl_q;
    row_vld_d = row_vld_q;
    if (gnt_found) begin
      row_tbl_d[gnt_cmd[2:0]] = gnt_cmd[29:17];
      row_vld_d[gnt_cmd[2:0]] = 1'b1;
    end
  end

  // Row table and bypass counter registers
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      for (int b = 0; b < 8; b++) row_tbl_q[b] <= '0;
      row_vld_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      row_tbl_q <= row_tbl_d;
      row_vld_q <= row_vld_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end
`else
  // Grant is the plain round-robin choice
  always_comb begin
    gnt_found = rr_found;
    gnt_idx   = rr_idx;
  end
`endif

  // One-hot ready, next command register contents and RR pointer update
  always_comb begin
    req_ready = '0;
    gnt_cmd   = cmd_a[gnt_idx];
    gnt_rd    = gnt_cmd[31];
    cmd_d     = '0;
    wdata_d   = '0;
    valid_d   = gnt_found;
    rr_ptr_d  = rr_ptr_q;
    if (gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
      cmd_d              = gnt_cmd;
      if (!gnt_rd) wdata_d = wdata_a[gnt_idx];
      rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  // Tag FIFO push on read issue, pop on each returned beat, and response steering
  always_comb begin
    push        = gnt_found && gnt_rd;
    pop         = read_data_valid && (cnt_q != '0);
    tag_mem_d   = tag_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q | (read_data_valid && (cnt_q == '0));
    if (push) begin
      tag_mem_d[wr_ptr_q] = gnt_idx;
      wr_ptr_d            = wr_ptr_q + TAG_AW'(1);
    end
    if (pop) begin
      rd_ptr_d                       = rd_ptr_q + TAG_AW'(1);
      rsp_valid_d[tag_mem_q[rd_ptr_q]] = 1'b1;
      rsp_data_d                     = read_data;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (TAG_AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (TAG_AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Main register bank; reset empties the tag FIFO and clears every output
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      cmd_q       <= '0;
      valid_q     <= 1'b0;
      wdata_q     <= '0;
      rr_ptr_q    <= '0;
      for (int t = 0; t < TAG_DEPTH; t++) tag_mem_q[t] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      valid_q     <= valid_d;
      wdata_q     <= wdata_d;
      rr_ptr_q    <= rr_ptr_d;
      tag_mem_q   <= tag_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign command        = cmd_q;
  assign valid          = valid_q;
  assign write_data     = wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rd_outstanding = cnt_q;
  assign err_unexp_rd   = err_q;

endmodule

// File: tb/tb_dram_cmd_arbiter.sv
// Testbench for dram_cmd_arbiter: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_dram_cmd_arbiter;

  logic         clk;
  logic         power_on_rst_n;
  logic [1:0]   req_valid;
  logic [67:0]  req_cmd;
  logic [255:0] req_wdata;
  logic [1:0]   req_ready;
  logic [33:0]  command;
  logic         valid;
  logic [127:0] write_data;
  logic [7:0]   ba_cmd_pm;
  logic [127:0] read_data;
  logic         read_data_valid;
  logic [1:0]   rsp_valid;
  logic [127:0] rsp_data;
  logic [4:0]   rd_outstanding;
  logic         err_unexp_rd;

  int total = 0;
  int bad   = 0;

  dram_cmd_arbiter dut (
    .clk(clk), .power_on_rst_n(power_on_rst_n),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_wdata(req_wdata),
    .req_ready(req_ready), .command(command), .valid(valid),
    .write_data(write_data), .ba_cmd_pm(ba_cmd_pm), .read_data(read_data),
    .read_data_valid(read_data_valid), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rd_outstanding(rd_outstanding),
    .err_unexp_rd(err_unexp_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [33:0] mk_cmd(input logic [1:0] rank, input logic rw,
                                         input logic [12:0] row, input logic bl,
                                         input logic ap, input logic [9:0] col,
                                         input logic [2:0] bank);
    return {rank, rw, 1'b0, row, 1'b0, bl, 1'b0, ap, col, bank};
  endfunction

  task automatic set_req(input int k, input logic v, input logic [33:0] c,
                         input logic [127:0] w);
    req_valid[k]           = v;
    req_cmd[k*34 +: 34]    = c;
    req_wdata[k*128 +: 128] = w;
  endtask

  task automatic do_reset();
    power_on_rst_n  = 1'b0;
    req_valid       = '0;
    req_cmd         = '0;
    req_wdata       = '0;
    ba_cmd_pm       = '0;
    read_data       = '0;
    read_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    power_on_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    power_on_rst_n = 1'b0;
    #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", valid); end
    total++; if (command !== 34'd0) begin bad++; $display("FAIL rst_command got=%h exp=0", command); end
    total++; if (write_data !== 128'd0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", write_data); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid); end
    total++; if (rd_outstanding !== 5'd0) begin bad++; $display("FAIL rst_outstanding got=%0d exp=0", rd_outstanding); end
    total++; if (err_unexp_rd !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", err_unexp_rd); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
    @(negedge clk);
    power_on_rst_n = 1'b1;
    // Leave a read outstanding, then reset: the late beat must be flagged unexpected
    @(negedge clk);
    ba_cmd_pm = 8'hff;
    set_req(0, 1'b1, mk_cmd(0, 1, 13'd7, 0, 0, 10'd1, 3'd1), '0);
    @(posedge clk); #1;
    total++; if (rd_outstanding !== 5'd1) begin bad++; $display("FAIL rst_pre_tag got=%0d exp=1", rd_outstanding); end
    do_reset();
    @(negedge clk);
    read_data_valid = 1'b1;
    read_data       = 128'hdead;
    @(posedge clk); #1;
    read_data_valid = 1'b0;
    total++; if (err_unexp_rd !== 1'b1) begin bad++; $display("FAIL rst_late_beat_err got=%0b exp=1", err_unexp_rd); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_late_beat_rsp got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_single_write();
    logic [33:0]  c;
    logic [127:0] w;
    do_reset();
    c = mk_cmd(0, 0, 13'd5, 0, 0, 10'd3, 3'd0);
    w = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    @(negedge clk);
    ba_cmd_pm = 8'h01;
    set_req(0, 1'b1, c, w);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL sw_ready got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL sw_valid got=%0b exp=1", valid); end
    total++; if (command !== c) begin bad++; $display("FAIL sw_command got=%h exp=%h", command, c); end
    total++; if (write_data !== w) begin bad++; $display("FAIL sw_wdata got=%h exp=%h", write_data, w); end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL sw_valid_drop got=%0b exp=0", valid); end
    total++; if (command !== 34'd0) begin bad++; $display("FAIL sw_cmd_zero got=%h exp=0", command); end
    total++; if (write_data !== 128'd0) begin bad++; $display("FAIL sw_wdata_zero got=%h exp=0", write_data); end
  endtask

  task automatic test_back_to_back();
    logic [33:0] c [2];
    logic [1:0]  exp_rdy;
    do_reset();
    c[0] = mk_cmd(1, 0, 13'd10, 0, 0, 10'd4, 3'd0);
    c[1] = mk_cmd(2, 0, 13'd20, 1, 1, 10'd8, 3'd0);
    @(negedge clk);
    ba_cmd_pm = 8'h01;
    set_req(0, 1'b1, c[0], 128'h1111);
    set_req(1, 1'b1, c[1], 128'h2222);
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, req_ready, exp_rdy); end
      @(posedge clk); #1;
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%0b exp=1", i, valid); end
      total++; if (command !== c[i%2]) begin bad++; $display("FAIL b2b_cmd[%0d] got=%h exp=%h", i, command, c[i%2]); end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_bank_perm();
    do_reset();
    @(negedge clk);
    ba_cmd_pm = 8'h01;
    set_req(0, 1'b1, mk_cmd(0, 0, 13'd1, 0, 0, 10'd0, 3'd2), 128'haa);
    set_req(1, 1'b1, mk_cmd(0, 0, 13'd1, 0, 0, 10'd0, 3'd0), 128'hbb);
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL perm_blocked got=%b exp=10", req_ready); end
    @(posedge clk); #1;
    total++; if (write_data !== 128'hbb) begin bad++; $display("FAIL perm_wdata got=%h exp=bb", write_data); end
    @(negedge clk);
    ba_cmd_pm = 8'h05;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL perm_open got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_read_return();
    logic [127:0] beat [3];
    logic [1:0]   exp_rsp [3];
    beat[0] = 128'hA; beat[1] = 128'hB; beat[2] = 128'hC;
    exp_rsp[0] = 2'b01; exp_rsp[1] = 2'b10; exp_rsp[2] = 2'b01;
    do_reset();
    @(negedge clk);
    ba_cmd_pm = 8'hff;
    set_req(0, 1'b1, mk_cmd(0, 1, 13'd1, 0, 0, 10'd0, 3'd0), '1);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rd_ready0 got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    total++; if (write_data !== 128'd0) begin bad++; $display("FAIL rd_wdata_zero got=%h exp=0", write_data); end
    @(negedge clk);
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b1, mk_cmd(0, 1, 13'd2, 0, 0, 10'd0, 3'd0), '0);
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rd_ready1 got=%b exp=10", req_ready); end
    @(negedge clk);
    set_req(1, 1'b0, '0, '0);
    set_req(0, 1'b1, mk_cmd(0, 1, 13'd3, 0, 0, 10'd0, 3'd0), '0);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rd_ready2 got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    total++; if (rd_outstanding !== 5'd3) begin bad++; $display("FAIL rd_outstanding3 got=%0d exp=3", rd_outstanding); end
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      read_data_valid = 1'b1;
      read_data       = beat[i];
      @(posedge clk); #1;
      total++; if (rsp_valid !== exp_rsp[i]) begin bad++; $display("FAIL rd_rsp_valid[%0d] got=%b exp=%b", i, rsp_valid, exp_rsp[i]); end
      total++; if (rsp_data !== beat[i]) begin bad++; $display("FAIL rd_rsp_data[%0d] got=%h exp=%h", i, rsp_data, beat[i]); end
      total++; if (rd_outstanding !== 5'(2 - i)) begin bad++; $display("FAIL rd_outstanding_dec[%0d] got=%0d exp=%0d", i, rd_outstanding, 2 - i); end
      @(negedge clk);
    end
    read_data_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rd_rsp_idle got=%b exp=00", rsp_valid); end
    total++; if (rsp_data !== beat[2]) begin bad++; $display("FAIL rd_rsp_hold got=%h exp=%h", rsp_data, beat[2]); end
  endtask

  task automatic test_tag_full();
    logic [33:0] rd_c;
    rd_c = mk_cmd(0, 1, 13'd9, 0, 0, 10'd2, 3'd0);
    do_reset();
    @(negedge clk);
    ba_cmd_pm = 8'hff;
    set_req(0, 1'b1, rd_c, '0);
    repeat (16) @(negedge clk);
    set_req(0, 1'b0, '0, '0);
    #1;
    total++; if (rd_outstanding !== 5'd16) begin bad++; $display("FAIL full_count got=%0d exp=16", rd_outstanding); end
    set_req(1, 1'b1, mk_cmd(0, 0, 13'd9, 0, 0, 10'd2, 3'd0), 128'h77);
    @(negedge clk);
    set_req(0, 1'b1, rd_c, '0);
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL full_write_ok got=%b exp=10", req_ready); end
    @(negedge clk);
    set_req(1, 1'b0, '0, '0);
    read_data_valid = 1'b1;
    read_data       = 128'h55;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL full_pop_same_cycle got=%b exp=00", req_ready); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL full_pop_rsp got=%b exp=01", rsp_valid); end
    total++; if (rd_outstanding !== 5'd15) begin bad++; $display("FAIL full_after_pop got=%0d exp=15", rd_outstanding); end
    @(negedge clk);
    read_data_valid = 1'b0;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL full_unblock got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid       = '0;
    read_data_valid = 1'b1;
    repeat (16) @(negedge clk);
    read_data_valid = 1'b0;
    #1;
    total++; if (rd_outstanding !== 5'd0) begin bad++; $display("FAIL full_drain got=%0d exp=0", rd_outstanding); end
    total++; if (err_unexp_rd !== 1'b0) begin bad++; $display("FAIL full_no_err got=%0b exp=0", err_unexp_rd); end
    @(negedge clk);
    read_data_valid = 1'b1;
    @(posedge clk); #1;
    read_data_valid = 1'b0;
    total++; if (err_unexp_rd !== 1'b1) begin bad++; $display("FAIL empty_err got=%0b exp=1", err_unexp_rd); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL empty_no_rsp got=%b exp=00", rsp_valid); end
  endtask

`ifdef DRAM_ARB_ROW_HIT_EN
  task automatic test_row_hit();
    logic [1:0] exp_rdy [4];
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b10;
    do_reset();
    @(negedge clk);
    ba_cmd_pm = 8'h01;
    set_req(0, 1'b1, mk_cmd(0, 0, 13'd100, 0, 0, 10'd0, 3'd0), 128'h1);
    @(negedge clk);
    set_req(1, 1'b1, mk_cmd(0, 0, 13'd200, 0, 0, 10'd0, 3'd0), 128'h2);
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (req_ready !== exp_rdy[i]) begin bad++; $display("FAIL rowhit_ready[%0d] got=%b exp=%b", i, req_ready, exp_rdy[i]); end
      @(negedge clk);
    end
    req_valid = '0;
  endtask
`endif

  task automatic test_random();
    int           rr;
    int           tagq[$];
    int           g;
    int           h;
    int           k;
    int           popped;
    bit           err;
    logic [127:0] rdat;
    logic [33:0]  c [2];
    logic [127:0] w [2];
    bit           el [2];
    logic [1:0]   exp_rdy;
    logic [1:0]   exp_rsp;
    logic [33:0]  exp_cmd;
    logic [127:0] exp_wd;
    logic [12:0]  mrow [8];
    bit           mvld [8];
    int           hits;
    do_reset();
    rr = 0; err = 0; rdat = '0; hits = 0;
    tagq.delete();
    for (int b = 0; b < 8; b++) begin mrow[b] = '0; mvld[b] = 0; end
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int q = 0; q < 2; q++) begin
        c[q] = mk_cmd(2'($urandom), 1'($urandom), 13'($urandom_range(0, 3)), 1'($urandom),
                      1'($urandom), 10'($urandom), 3'($urandom));
        w[q] = {$urandom, $urandom, $urandom, $urandom};
        set_req(q, ($urandom_range(0, 3) != 0), c[q], w[q]);
      end
      ba_cmd_pm       = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hff;
      read_data_valid = ($urandom_range(0, 3) == 0);
      read_data       = {$urandom, $urandom, $urandom, $urandom};
      for (int q = 0; q < 2; q++)
        el[q] = req_valid[q] && ba_cmd_pm[c[q][2:0]] && !(c[q][31] && tagq.size() == 16);
      g = -1;
      for (int i = 0; i < 2; i++) begin
        k = (rr + i) % 2;
        if (g < 0 && el[k]) g = k;
      end
`ifdef DRAM_ARB_ROW_HIT_EN
      h = -1;
      for (int i = 0; i < 2; i++) begin
        k = (rr + i) % 2;
        if (h < 0 && el[k] && mvld[c[k][2:0]] && mrow[c[k][2:0]] == c[k][29:17]) h = k;
      end
      if (g >= 0) begin
        if (hits == 3) hits = 0;
        else if (h >= 0 && h != g) begin g = h; hits++; end
        else hits = 0;
      end
      if (g >= 0) begin mrow[c[g][2:0]] = c[g][29:17]; mvld[c[g][2:0]] = 1; end
`else
      h = -1;
`endif
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      #1;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", n, req_ready, exp_rdy); end
      exp_cmd = (g >= 0) ? c[g] : '0;
      exp_wd  = (g >= 0 && !c[g][31]) ? w[g] : '0;
      popped = -1;
      if (read_data_valid) begin
        if (tagq.size() > 0) popped = tagq.pop_front();
        else err = 1;
      end
      if (g >= 0 && c[g][31]) tagq.push_back(g);
      if (g >= 0) rr = (g + 1) % 2;
      exp_rsp = '0;
      if (popped >= 0) begin exp_rsp[popped] = 1'b1; rdat = read_data; end
      @(posedge clk); #1;
      total++; if (valid !== (g >= 0)) begin bad++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", n, valid, g >= 0); end
      total++; if (command !== exp_cmd) begin bad++; $display("FAIL rnd_cmd[%0d] got=%h exp=%h", n, command, exp_cmd); end
      total++; if (write_data !== exp_wd) begin bad++; $display("FAIL rnd_wdata[%0d] got=%h exp=%h", n, write_data, exp_wd); end
      total++; if (rsp_valid !== exp_rsp) begin bad++; $display("FAIL rnd_rsp_valid[%0d] got=%b exp=%b", n, rsp_valid, exp_rsp); end
      total++; if (rsp_data !== rdat) begin bad++; $display("FAIL rnd_rsp_data[%0d] got=%h exp=%h", n, rsp_data, rdat); end
      total++; if (rd_outstanding !== 5'(tagq.size())) begin bad++; $display("FAIL rnd_outstanding[%0d] got=%0d exp=%0d", n, rd_outstanding, tagq.size()); end
      total++; if (err_unexp_rd !== err) begin bad++; $display("FAIL rnd_err[%0d] got=%0b exp=%0b", n, err_unexp_rd, err); end
    end
    @(negedge clk);
    req_valid       = '0;
    read_data_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_bank_perm();
    test_read_return();
    test_tag_full();
`ifdef DRAM_ARB_ROW_HIT_EN
    test_row_hit();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_cmd_arbiter.md
Name: dram_cmd_arbiter

Overview:
- Shares the single 34-bit command / 128-bit write-data port of the DRAM memory controller between NUM_REQ requesters, e.g. two image-stream masters.
- Issues at most one command per cycle, and only to banks whose `ba_cmd_pm` permission bit is set.
- Records the originator of every read in an in-order tag FIFO.
- Routes each returned `read_data` beat back to the requester that issued the read.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- CMD_W, 34, command width. Format {rank[33:32], rw[31] (0=write, 1=read), 0, row[29:17], 0, bl[15], 0, auto_pre[13], col[12:3], bank[2:0]}.
- DATA_W, 128, write/read data width (DQ_BITS*8).
- TAG_DEPTH, 16, outstanding-read tag FIFO depth (power of 2).
- TAG_AW, 4, log2(TAG_DEPTH).

Ports:
- clk, input, 1, system clock; all logic on posedge.
- power_on_rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, NUM_REQ, requester k has a command pending.
- req_cmd, input, NUM_REQ*CMD_W, command of requester k at slice k.
- req_wdata, input, NUM_REQ*DATA_W, write data of requester k; sampled only for writes.
- req_ready, output, NUM_REQ, combinational one-hot grant; transfer when req_valid[k] && req_ready[k].
- command, output, CMD_W, registered command to the controller.
- valid, output, 1, registered command strobe.
- write_data, output, DATA_W, registered write data; 0 for reads.
- ba_cmd_pm, input, 8, per-bank command permission from the controller.
- read_data, input, DATA_W, read data from the controller.
- read_data_valid, input, 1, read_data qualifier, one beat per read.
- rsp_valid, output, NUM_REQ, one-hot read-return strobe.
- rsp_data, output, DATA_W, returned read data, shared by all requesters.
- rd_outstanding, output, TAG_AW+1, current tag FIFO occupancy.
- err_unexp_rd, output, 1, sticky: read_data_valid seen while tag FIFO empty.

Behaviour:
- Reset: all outputs 0, tag FIFO empty, RR pointer = 0. Reset asserted mid-operation discards pending tags; read beats arriving after reset set err_unexp_rd.
- Eligibility of requester k: req_valid[k] && ba_cmd_pm[req_cmd_k[2:0]] && !(req_cmd_k[31] && tag_full).
- Tag-full blocking: a read is blocked when the FIFO is full, even if a pop occurs the same cycle. Writes are never blocked by the FIFO.
- Round robin: among eligible requesters, grant the first at or after rr_ptr (wrapping). After a grant, rr_ptr = granted+1 mod NUM_REQ; with no grant, rr_ptr holds.
- req_ready is combinational from the current-cycle inputs and state, and at most one bit is set.
- Issue latency: command granted in cycle N appears on command/valid/write_data after the posedge ending cycle N, and is held for exactly one cycle.
- When valid=0, command=0 and write_data=0. Back-to-back issue every cycle is allowed.
- Read issue: a granted read pushes the requester index into the tag FIFO in the same edge that registers the command.
- Return: each read_data_valid pops one tag. One cycle later, rsp_valid[tag]=1 and rsp_data=read_data; otherwise rsp_valid=0 and rsp_data holds its last value.
- Simultaneous push and pop is allowed: occupancy is unchanged and ordering is preserved.
- Return with empty FIFO: read_data_valid is dropped, no rsp_valid is asserted, and err_unexp_rd is set (cleared only by reset).
- rd_outstanding = push count − pop count, range 0..TAG_DEPTH.
- Command fields pass through unmodified; the block never reorders commands from one requester.

Optional Feature:
- Macro: DRAM_ARB_ROW_HIT_EN.
- Enabled:
  - Keep a last-issued row register (13 bits) plus valid bit per bank (8 banks), updated on every issue.
  - An eligible requester whose row matches its bank's last row (row hit) is preferred over RR order; RR order breaks ties among hits.
  - A 2-bit counter limits consecutive hit-preferred grants that bypass RR order to 3; the next grant is then pure RR and the counter clears.
  - Row table is cleared by reset.
- Disabled: pure round robin, and no row table exists.

Test Plan:
1. Reset, then req 0 writes {row=5, col=3, bank=0} with ba_cmd_pm=8'h01 → req_ready=2'b01 same cycle; valid=1 next cycle, command equal to req_cmd, write_data equal to the requester's data.
2. Both requesters hold valid continuously with bank 0 permitted → grants alternate 0,1,0,1, and valid is high every cycle.
3. Req 0 targets bank 2 with ba_cmd_pm[2]=0, req 1 targets bank 0 → only req 1 is granted; after ba_cmd_pm[2] rises, req 0 is granted next cycle.
4. Interleaved reads (req0 row1, req1 row2, req0 row3), then three read_data_valid beats A, B, C → rsp_valid sequence 01, 10, 01 with rsp_data A, B, C one cycle after each beat; rd_outstanding goes 3→0.
5. Issue 16 reads with no returns → the 17th read stalls (req_ready=0) while a write from the other requester is still granted. A single read_data_valid beat alone does not unblock the stalled read in that same cycle; it is granted the cycle after the pop. With no tags outstanding, a lone read_data_valid sets err_unexp_rd=1 and produces no rsp_valid.
6. With DRAM_ARB_ROW_HIT_EN defined: rr_ptr favours req 1, req0 row hit vs req1 row miss on bank 0 → req 0 is granted 3 times, then req 1 is granted.
